// File: rtl/sram_stream_reader.sv
// Streams LEN consecutive words from a one-cycle-latency SRAM port out as a
// valid/ready stream with a last flag. Optional SRAM_RD_STRIDE_EN adds a STRIDE input.
module sram_stream_reader #(
  parameter int BITS       = 64,
  parameter int ADDR_WIDTH = 15,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [ADDR_WIDTH-1:0] START_ADDR,
  input  logic [LEN_WIDTH-1:0]  LEN,
`ifdef SRAM_RD_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] STRIDE,
`endif
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  CEN,
  output logic [1:0]            WEN,
  output logic [ADDR_WIDTH-1:0] A,
  input  logic [BITS-1:0]       Q,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [BITS-1:0]       OUT_DATA,
  output logic                  OUT_LAST
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] step;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  inflight;
  logic                  inflight_last;
  logic [BITS-1:0]       fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         credit_used;
  logic                  issue;
  logic                  push;
  logic                  pop;

`ifdef SRAM_RD_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q;

  always_ff @(posedge CLK) begin
    if (RST)                        stride_q <= '0;
    else if (state == IDLE && START) stride_q <= STRIDE;
  end

  assign step = stride_q;
`else
  assign step = ADDR_WIDTH'(1);
`endif

  // A read reserves a FIFO slot for its return word; the in-flight word counts
  // against the credit so the FIFO can never be overrun.
  assign credit_used = count + CW'(inflight);
  assign issue       = (state == ISSUE) && (credit_used < CW'(FIFO_DEPTH));
  assign push        = inflight;
  assign pop         = OUT_VALID && OUT_READY;

  assign CEN       = ~issue;
  assign WEN       = 2'b11;
  assign A         = addr;
  assign BUSY      = (state != IDLE);
  assign OUT_VALID = (count != '0);
  assign OUT_DATA  = fifo_data[rd_ptr];
  assign OUT_LAST  = OUT_VALID && fifo_last[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      addr          <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      DONE          <= 1'b0;
    end else begin
      DONE          <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && (remaining == LEN_WIDTH'(1));
      case (state)
        IDLE: begin
          if (START) begin
            if (LEN == '0) begin
              DONE <= 1'b1;
            end else begin
              addr      <= START_ADDR;
              remaining <= LEN;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            addr      <= addr + step;
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && OUT_LAST) begin
            state <= IDLE;
            DONE  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the FIFO storage is cleared on reset so OUT_DATA reads zero after
  // reset; at this depth that costs only a few reset muxes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_last <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_data[i] <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= Q;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed bench for sram_stream_reader: table of transfers against a mem[i]=i
// SRAM model, plus hand-written reset-abort and stride sequences.
module tb_sram_stream_reader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [14:0] START_ADDR;
  logic [15:0] LEN;
  logic [14:0] STRIDE;
  logic        BUSY, DONE, CEN;
  logic [1:0]  WEN;
  logic [14:0] A;
  logic [63:0] Q;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [63:0] OUT_DATA;
  logic        OUT_LAST;

  always #5 CLK = ~CLK;

  sram_stream_reader dut (
    .CLK(CLK), .RST(RST), .START(START), .START_ADDR(START_ADDR), .LEN(LEN),
`ifdef SRAM_RD_STRIDE_EN
    .STRIDE(STRIDE),
`endif
    .BUSY(BUSY), .DONE(DONE), .CEN(CEN), .WEN(WEN), .A(A), .Q(Q),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_LAST(OUT_LAST)
  );

  // SRAM model: one-cycle read latency, output holds its last value.
  logic [63:0] mem [32768];
  logic [63:0] q_r = '1;
  assign Q = q_r;
  initial for (int i = 0; i < 32768; i++) mem[i] = 64'(i);
  always @(posedge CLK) if (CEN === 1'b0) q_r <= mem[A];

  typedef struct {
    logic [14:0] start_addr;
    logic [15:0] len;
    logic [14:0] stride;
    int          ready_mode;
    int          restart_at;
    int          exp_beats;
    logic [63:0] exp_first;
    logic [63:0] exp_last;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Observation log, filled at the falling edge.
  int          cyc = 0;
  int          start_cyc, first_cen_cyc, first_valid_cyc, last_beat_cyc, done_cyc;
  int          done_cnt, wen_bad, stall_bad, issued, popped, max_out;
  bit          stall_prev;
  logic [63:0] stall_data;
  logic        stall_last;
  logic [63:0] beat_q[$];
  logic        last_q[$];
  logic [14:0] addr_q[$];

  task automatic clear_logs();
    start_cyc = -100; first_cen_cyc = -1; first_valid_cyc = -1;
    last_beat_cyc = -1; done_cyc = -1;
    done_cnt = 0; wen_bad = 0; stall_bad = 0; issued = 0; popped = 0; max_out = 0;
    stall_prev = 1'b0;
    beat_q.delete(); last_q.delete(); addr_q.delete();
  endtask

  always @(negedge CLK) begin
    cyc++;
    if (RST === 1'b0) begin
      if (issued - popped > max_out) max_out = issued - popped;
      if (START === 1'b1 && BUSY === 1'b0) start_cyc = cyc;
      if (CEN === 1'b0) begin
        if (addr_q.size() == 0) first_cen_cyc = cyc;
        addr_q.push_back(A);
        issued++;
      end
      if (OUT_VALID === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (WEN !== 2'b11) wen_bad++;
      if (stall_prev && !(OUT_VALID === 1'b1 && OUT_DATA === stall_data && OUT_LAST === stall_last))
        stall_bad++;
      stall_prev = (OUT_VALID === 1'b1) && (OUT_READY === 1'b0);
      stall_data = OUT_DATA;
      stall_last = OUT_LAST;
      if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
        beat_q.push_back(OUT_DATA);
        last_q.push_back(OUT_LAST);
        last_beat_cyc = cyc;
        popped++;
      end
      if (DONE === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic ready_for(input int mode, input int k);
    return (mode == 0) ? 1'b1 : ((k % 3) == 0);
  endfunction

  task automatic run_xfer(input vec_t v, output bit timed_out);
    int k;
    clear_logs();
    k = 0;
    while (done_cnt == 0 && k < 200) begin
      OUT_READY = ready_for(v.ready_mode, k);
      if (k == 0) begin
        START = 1'b1; START_ADDR = v.start_addr; LEN = v.len; STRIDE = v.stride;
      end else if (k == v.restart_at) begin
        START = 1'b1; START_ADDR = 15'd100; LEN = 16'd3; STRIDE = 15'd1;
      end else begin
        START = 1'b0;
      end
      @(posedge CLK); #1;
      k++;
    end
    START = 1'b0;
    timed_out = (done_cnt == 0);
    repeat (3) begin @(posedge CLK); #1; end
  endtask

  task automatic verify(input vec_t v, input int id, input bit timed_out);
    int          bad_last, bad_addr;
    logic [14:0] ea;
    string       p;
    p = $sformatf("v%0d", id);
    check({p, " done_seen"}, 64'(!timed_out), 64'd1);
    check({p, " beats"}, 64'(beat_q.size()), 64'(v.exp_beats));
    check({p, " cen_cycles"}, 64'(addr_q.size()), 64'(v.len));
    check({p, " done_pulses"}, 64'(done_cnt), 64'd1);
    check({p, " wen_bad"}, 64'(wen_bad), 64'd0);
    check({p, " stall_unstable"}, 64'(stall_bad), 64'd0);
    check({p, " credit_le_depth"}, 64'(max_out <= 4), 64'd1);
    check({p, " busy_after"}, 64'(BUSY), 64'd0);
    if (v.len == 0) begin
      check({p, " done_latency"}, 64'(done_cyc), 64'(start_cyc + 1));
    end else begin
      bad_last = 0;
      bad_addr = 0;
      for (int i = 0; i < beat_q.size(); i++) begin
        ea = v.start_addr + 15'(i * int'(v.stride));
        check($sformatf("%s data%0d", p, i), beat_q[i], mem[ea]);
        if (last_q[i] !== (i == int'(v.len) - 1)) bad_last++;
      end
      for (int i = 0; i < addr_q.size(); i++) begin
        ea = v.start_addr + 15'(i * int'(v.stride));
        if (addr_q[i] !== ea) bad_addr++;
      end
      check({p, " last_tags"}, 64'(bad_last), 64'd0);
      check({p, " addr_seq"}, 64'(bad_addr), 64'd0);
      if (beat_q.size() > 0) begin
        check({p, " first_word"}, beat_q[0], v.exp_first);
        check({p, " last_word"}, beat_q[beat_q.size()-1], v.exp_last);
      end
      check({p, " first_cen"}, 64'(first_cen_cyc), 64'(start_cyc + 1));
      check({p, " first_valid"}, 64'(first_valid_cyc), 64'(start_cyc + 3));
      check({p, " done_after_last"}, 64'(done_cyc), 64'(last_beat_cyc + 1));
      if (v.ready_mode == 0)
        check({p, " back_to_back"}, 64'(last_beat_cyc), 64'(start_cyc + 2 + int'(v.len)));
    end
  endtask

  vec_t vecs[$];
  vec_t post_rst;
  bit   to;
  int   k;

  initial begin
    //               addr       len    stride  mode restart beats first       last
    vecs.push_back('{15'd10,    16'd5, 15'd1,  0,   -1,     5,    64'd10,     64'd14});
    vecs.push_back('{15'd200,   16'd8, 15'd1,  1,   -1,     8,    64'd200,    64'd207});
    vecs.push_back('{15'd32766, 16'd4, 15'd1,  0,   -1,     4,    64'd32766,  64'd1});
    vecs.push_back('{15'd50,    16'd0, 15'd1,  0,   -1,     0,    64'd0,      64'd0});
    vecs.push_back('{15'd300,   16'd6, 15'd1,  0,    2,     6,    64'd300,    64'd305});
    vecs.push_back('{15'd1000,  16'd1, 15'd1,  1,   -1,     1,    64'd1000,   64'd1000});
`ifdef SRAM_RD_STRIDE_EN
    vecs.push_back('{15'd0,     16'd3, 15'd4,  0,   -1,     3,    64'd0,      64'd8});
`endif
    post_rst = '{15'd600, 16'd2, 15'd1, 0, -1, 2, 64'd600, 64'd601};

    RST = 1'b1; START = 1'b0; START_ADDR = '0; LEN = '0; STRIDE = 15'd1; OUT_READY = 1'b0;
    clear_logs();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst BUSY", 64'(BUSY), 64'd0);
    check("rst DONE", 64'(DONE), 64'd0);
    check("rst CEN", 64'(CEN), 64'd1);
    check("rst WEN", 64'(WEN), 64'd3);
    check("rst A", 64'(A), 64'd0);
    check("rst OUT_VALID", 64'(OUT_VALID), 64'd0);
    check("rst OUT_DATA", OUT_DATA, 64'd0);
    check("rst OUT_LAST", 64'(OUT_LAST), 64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    foreach (vecs[i]) begin
      run_xfer(vecs[i], to);
      verify(vecs[i], i, to);
    end

    // Abort a LEN=10 transfer while its third beat is on the output.
    clear_logs();
    OUT_READY = 1'b1; START = 1'b1; START_ADDR = 15'd500; LEN = 16'd10; STRIDE = 15'd1;
    @(posedge CLK); #1;
    START = 1'b0;
    k = 0;
    while (beat_q.size() < 2 && k < 50) begin @(posedge CLK); #1; k++; end
    check("abort reached beat3", 64'(k < 50), 64'd1);
    check("abort beat3 valid", 64'(OUT_VALID), 64'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("abort CEN", 64'(CEN), 64'd1);
    check("abort OUT_VALID", 64'(OUT_VALID), 64'd0);
    check("abort BUSY", 64'(BUSY), 64'd0);
    check("abort DONE", 64'(DONE), 64'd0);
    check("abort A", 64'(A), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check($sformatf("abort quiet%0d valid", i), 64'(OUT_VALID), 64'd0);
    end
    check("abort no DONE", 64'(done_cnt), 64'd0);
    @(posedge CLK); #1;
    run_xfer(post_rst, to);
    verify(post_rst, 99, to);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
